// File: rtl/mem_bus_arbiter_if.sv
// CPU / DMA / memory bus bundle for mem_bus_arbiter.
// With MEM_BUS_ROM_WP_EN defined the bundle also carries the wp_hit pulse.
interface mem_bus_arbiter_if;
  logic [19:0] cpu_a;
  logic [7:0]  cpu_o;
  logic        cpu_w;
  logic [7:0]  cpu_i;
  logic        cpu_ce;
  logic        dma_req;
  logic [19:0] dma_a;
  logic [7:0]  dma_o;
  logic        dma_w;
  logic        dma_gnt;
  logic        dma_ack;
  logic [7:0]  dma_i;
  logic [19:0] mem_a;
  logic [7:0]  mem_o;
  logic        mem_w;
  logic [7:0]  mem_i;
`ifdef MEM_BUS_ROM_WP_EN
  logic        wp_hit;
`endif

  // arbiter view
  modport master (
    input  cpu_a, cpu_o, cpu_w, dma_req, dma_a, dma_o, dma_w, mem_i,
    output cpu_i, cpu_ce, dma_gnt, dma_ack, dma_i, mem_a, mem_o, mem_w
`ifdef MEM_BUS_ROM_WP_EN
    , output wp_hit
`endif
  );

  // CPU, requester and memory decoder view
  modport slave (
    output cpu_a, cpu_o, cpu_w, dma_req, dma_a, dma_o, dma_w, mem_i,
    input  cpu_i, cpu_ce, dma_gnt, dma_ack, dma_i, mem_a, mem_o, mem_w
`ifdef MEM_BUS_ROM_WP_EN
    , input wp_hit
`endif
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares the 20-bit memory bus between the c86 CPU and one DMA requester with bounded bursts.
// Optional BIOS write protect: define MEM_BUS_ROM_WP_EN.
module mem_bus_arbiter #(
  parameter int          BURST    = 8,
  parameter logic [19:0] ROM_BASE = 20'hFF800
) (
  input  logic             clock,
  input  logic             reset,
  mem_bus_arbiter_if.master bus
);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic {S_CPU, S_DMA} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dma_gnt_q, dma_gnt_d;
  logic            dma_ack_q, dma_ack_d;
  logic [7:0]      dma_i_q, dma_i_d;
  logic            wp_hit_q, wp_hit_d;

  logic            in_dma, access, wr_req, wr_blk;
  logic [19:0]     addr;

  always_comb begin
    in_dma = (state_q == S_DMA);
    access = in_dma & bus.dma_req;
    addr   = in_dma ? bus.dma_a : bus.cpu_a;
    wr_req = in_dma ? (access & bus.dma_w) : bus.cpu_w;
`ifdef MEM_BUS_ROM_WP_EN
    wr_blk = (addr >= ROM_BASE);
`else
    wr_blk = 1'b0;
`endif
  end

  assign bus.mem_a  = addr;
  assign bus.mem_o  = in_dma ? bus.dma_o : bus.cpu_o;
  // reset gates both strobes so no write lands while the state is being cleared
  assign bus.mem_w  = wr_req & ~wr_blk & ~reset;
  assign bus.cpu_ce = ~in_dma & ~reset;
  assign bus.cpu_i  = bus.mem_i;
  assign bus.dma_gnt = dma_gnt_q;
  assign bus.dma_ack = dma_ack_q;
  assign bus.dma_i   = dma_i_q;
`ifdef MEM_BUS_ROM_WP_EN
  assign bus.wp_hit  = wp_hit_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CPU: begin
        cnt_d = '0;
        if (bus.dma_req) state_d = S_DMA;
      end
      S_DMA: begin
        if (!bus.dma_req) begin
          state_d = S_CPU;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // burst exhausted: hand the CPU exactly one cycle
          state_d = S_CPU;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_CPU;
        cnt_d   = '0;
      end
    endcase
    dma_gnt_d = (state_d == S_DMA);
    dma_ack_d = access;
    dma_i_d   = (access && !bus.dma_w) ? bus.mem_i : dma_i_q;
    wp_hit_d  = wr_req & wr_blk;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_CPU;
      cnt_q     <= '0;
      dma_gnt_q <= 1'b0;
      dma_ack_q <= 1'b0;
      dma_i_q   <= 8'h00;
      wp_hit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dma_gnt_q <= dma_gnt_d;
      dma_ack_q <= dma_ack_d;
      dma_i_q   <= dma_i_d;
      wp_hit_q  <= wp_hit_d;
    end
  end

`ifndef MEM_BUS_ROM_WP_EN
  logic unused_ok;
  assign unused_ok = ^{wp_hit_q, ROM_BASE};
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small byte memory model on the shared bus.
module tb_mem_bus_arbiter;
  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   wr_cnt = 0;
  logic [7:0] mem_model [4096];

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.BURST(8), .ROM_BASE(20'hFF800)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // 0x002xx is a preloaded read-only region holding 0x80 + low address byte
  assign bus.mem_i = (bus.mem_a[19:8] == 12'h002) ? (8'h80 + bus.mem_a[7:0])
                                                   : mem_model[bus.mem_a[11:0]];

  always @(posedge clock) begin
    if (bus.mem_w) begin
      mem_model[bus.mem_a[11:0]] <= bus.mem_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [24:0] exp_g;
    int   idx, ack_idx, wr0;
    logic prev_acc, acc;

    reset = 1'b1;
    bus.cpu_a = 20'h00100; bus.cpu_o = 8'h5A; bus.cpu_w = 1'b1;
    bus.dma_req = 1'b0; bus.dma_a = '0; bus.dma_o = '0; bus.dma_w = 1'b0;
    step(); step();
    chk("rst_cpu_ce", bus.cpu_ce, 0);
    chk("rst_mem_w", bus.mem_w, 0);
    chk("rst_gnt", bus.dma_gnt, 0);
    chk("rst_ack", bus.dma_ack, 0);
    chk("rst_dma_i", bus.dma_i, 0);
    chk("rst_nowrite", wr_cnt, 0);

    // CPU-only traffic
    reset = 1'b0; bus.cpu_w = 1'b0;
    #1;
    chk("cpu_ce", bus.cpu_ce, 1);
    chk("cpu_mem_a", bus.mem_a, 20'h00100);
    bus.cpu_w = 1'b1;
    #1;
    chk("cpu_mem_w", bus.mem_w, 1);
    step();
    bus.cpu_w = 1'b0;
    #1;
    chk("cpu_readback", bus.cpu_i, 8'h5A);
    chk("cpu_gnt0", bus.dma_gnt, 0);
    bus.cpu_a = 20'h00345;
    #1;
    chk("cpu_mem_a2", bus.mem_a, 20'h00345);
    chk("cpu_ce2", bus.cpu_ce, 1);

    // DMA single write, then deassert while granted
    bus.dma_a = 20'hB8000; bus.dma_o = 8'h41; bus.dma_w = 1'b1; bus.dma_req = 1'b1;
    #1;
    chk("dw_gnt_pre", bus.dma_gnt, 0);
    chk("dw_ce_pre", bus.cpu_ce, 1);
    chk("dw_memw_pre", bus.mem_w, 0);
    step();
    chk("dw_gnt", bus.dma_gnt, 1);
    chk("dw_ce", bus.cpu_ce, 0);
    chk("dw_memw", bus.mem_w, 1);
    chk("dw_mem_a", bus.mem_a, 20'hB8000);
    step();
    bus.dma_req = 1'b0;
    #1;
    chk("dw_ack", bus.dma_ack, 1);
    chk("dw_data", mem_model[12'h000], 8'h41);
    chk("deas_memw", bus.mem_w, 0);
    chk("deas_gnt", bus.dma_gnt, 1);
    chk("deas_ce", bus.cpu_ce, 0);
    step();
    chk("deas_back_gnt", bus.dma_gnt, 0);
    chk("deas_back_ce", bus.cpu_ce, 1);
    chk("deas_noack", bus.dma_ack, 0);

    // 20 reads with dma_req held: 8 DMA, 1 CPU, 8 DMA, 1 CPU, 4 DMA, idle, CPU
    exp_g = 25'b0_1_1111_0_11111111_0_11111111_0;
    idx = 0; ack_idx = 0; prev_acc = 1'b0;
    bus.dma_w = 1'b0; bus.dma_a = 20'h00200; bus.dma_req = 1'b1;
    #1;
    for (int c = 0; c < 25; c++) begin
      chk($sformatf("burst_gnt_c%0d", c), bus.dma_gnt, exp_g[c]);
      chk($sformatf("burst_ce_c%0d", c), bus.cpu_ce, !exp_g[c]);
      chk($sformatf("burst_ack_c%0d", c), bus.dma_ack, prev_acc);
      if (bus.dma_ack) begin
        chk($sformatf("burst_data_%0d", ack_idx), bus.dma_i, 8'h80 + ack_idx[7:0]);
        ack_idx++;
      end
      acc = bus.dma_gnt & bus.dma_req;
      prev_acc = acc;
      step();
      if (acc) begin
        idx++;
        bus.dma_a = 20'h00200 + 20'(idx);
        if (idx == 20) bus.dma_req = 1'b0;
      end
      #1;
    end
    chk("burst_acks", ack_idx, 20);
    chk("burst_accesses", idx, 20);

    // reset during third beat of a DMA write burst
    bus.dma_w = 1'b1; bus.dma_a = 20'h00300; bus.dma_o = 8'h10; bus.dma_req = 1'b1;
    wr0 = wr_cnt;
    step();
    for (int k = 0; k < 2; k++) begin
      step();
      bus.dma_a = 20'h00301 + 20'(k); bus.dma_o = 8'h11 + 8'(k);
    end
    reset = 1'b1;
    #1;
    chk("rmid_memw", bus.mem_w, 0);
    chk("rmid_ce", bus.cpu_ce, 0);
    step();
    reset = 1'b0; bus.dma_req = 1'b0;
    #1;
    chk("rmid_gnt", bus.dma_gnt, 0);
    chk("rmid_ack", bus.dma_ack, 0);
    chk("rmid_ce_after", bus.cpu_ce, 1);
    chk("rmid_wrcnt", wr_cnt - wr0, 2);
    chk("rmid_beat1", mem_model[12'h301], 8'h11);
    step();
    chk("rmid_noack2", bus.dma_ack, 0);

`ifdef MEM_BUS_ROM_WP_EN
    bus.cpu_a = 20'hFF900; bus.cpu_o = 8'h77; bus.cpu_w = 1'b1;
    #1;
    chk("wp_cpu_memw", bus.mem_w, 0);
    step();
    bus.cpu_w = 1'b0;
    bus.dma_a = 20'hFFFF0; bus.dma_o = 8'h66; bus.dma_w = 1'b1; bus.dma_req = 1'b1;
    #1;
    chk("wp_cpu_hit", bus.wp_hit, 1);
    step();
    chk("wp_dma_memw", bus.mem_w, 0);
    chk("wp_dma_gnt", bus.dma_gnt, 1);
    step();
    bus.dma_req = 1'b0;
    #1;
    chk("wp_dma_ack", bus.dma_ack, 1);
    chk("wp_dma_hit", bus.wp_hit, 1);
    step();
    step();
    chk("wp_hit_clear", bus.wp_hit, 0);
    bus.cpu_a = 20'hFF7FF; bus.cpu_o = 8'h33; bus.cpu_w = 1'b1;
    #1;
    chk("wp_below_memw", bus.mem_w, 1);
    step();
    bus.cpu_w = 1'b0;
    #1;
    chk("wp_below_data", mem_model[12'h7FF], 8'h33);
    chk("wp_below_nohit", bus.wp_hit, 0);
`else
    bus.cpu_a = 20'hFF900; bus.cpu_o = 8'h77; bus.cpu_w = 1'b1;
    #1;
    chk("rom_pass_memw", bus.mem_w, 1);
    step();
    bus.cpu_w = 1'b0;
    #1;
    chk("rom_pass_data", mem_model[12'h900], 8'h77);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 20-bit byte-wide memory bus (32K RAM, 4K RAM, 8K video, 2K BIOS decode) between the c86 CPU and one DMA requester, e.g. a UART loader.
- Stalls the CPU through its `ce` input while the DMA owns the bus.
- Enforces a bounded DMA burst so the CPU is never starved.
- Sits between the c86 instance and the memory address decoder, all in the CPU `clock` domain.

Parameters:
- BURST, 8, maximum consecutive DMA access cycles before one forced CPU cycle (>=1).
- ROM_BASE, 20'hFF800, lowest BIOS address; used only with the optional feature.

Ports:
- clock  in  1  CPU clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cpu_a  in  20  CPU address.
- cpu_o  in  8  CPU write data.
- cpu_w  in  1  CPU write strobe.
- cpu_i  out  8  read data to CPU; combinational from mem_i.
- cpu_ce  out  1  CPU clock enable.
- dma_req  in  1  DMA access request; level.
- dma_a  in  20  DMA address.
- dma_o  in  8  DMA write data.
- dma_w  in  1  DMA write (1) / read (0).
- dma_gnt  out  1  DMA owns bus; registered.
- dma_ack  out  1  one-cycle pulse, access completed.
- dma_i  out  8  DMA read data, registered; valid with dma_ack.
- mem_a  out  20  shared bus address.
- mem_o  out  8  shared bus write data.
- mem_w  out  1  shared bus write strobe.
- mem_i  in  8  shared bus read data; valid in the same clock cycle as mem_a, because the memories run on the faster clock.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset values: state S_CPU, burst count 0, dma_gnt 0, dma_ack 0, dma_i 8'h00. While reset=1, cpu_ce=0 and mem_w=0.
- States:
  - S_CPU: mem_a/o=cpu_a/o; mem_w=cpu_w; cpu_ce=1; dma_gnt=0. The CPU cycle always completes.
    - dma_req=1 -> S_DMA.
    - else stay.
  - S_DMA: mem_a/o=dma_a/o; mem_w=dma_w&dma_req; cpu_ce=0; dma_gnt=1.
    - An access occurs in every cycle with dma_req&dma_gnt. The count increments on each access.
    - dma_req=0 -> S_CPU; no access; count cleared; that cycle is idle.
    - Access with count==BURST-1 -> S_CPU; count cleared. This forces exactly one CPU cycle even if dma_req stays 1, then back to S_DMA.
- cpu_ce=0 freezes the CPU; cpu_a/o/w are held by the CPU. mem_w never carries cpu_w while cpu_ce=0.
- dma_ack is registered. It pulses the cycle after each access (read or write). For reads, dma_i captures mem_i from the access cycle; for writes, dma_i is unchanged.
- DMA handshake:
  - The requester holds dma_a/o/w stable while dma_req=1 and dma_gnt=0.
  - It may advance to the next transfer on the edge ending a cycle with dma_req&dma_gnt.
  - It must not change dma_w mid-cycle.
- cpu_i is always mem_i. Its value is meaningful only in S_CPU cycles.
- Minimum DMA latency: 1 cycle from the dma_req rise to the first access (the gnt edge).
- Throughput with continuous dma_req: BURST DMA accesses per BURST+1 cycles.
- Count width is clog2(BURST) bits, minimum 1. It never exceeds BURST-1.
- BURST=1 gives strict alternation between CPU and DMA cycles.
- Reset mid-burst: next state S_CPU, no mem_w in the reset cycle, and no dma_ack after reset even if an access was in flight.

Optional Feature:
- Macro: MEM_BUS_ROM_WP_EN.
- Defined:
  - mem_w is forced 0 when mem_a >= ROM_BASE, for both requesters.
  - A DMA write to that range still produces dma_ack.
  - An extra output wp_hit (1 bit, registered, reset 0) pulses for one cycle after each blocked write.
- Undefined: there is no wp_hit port and writes pass through unfiltered.

Test Plan:
- Reset, then CPU-only traffic, dma_req=0: cpu_ce=1 every cycle; mem_a follows cpu_a; CPU write 8'h5A to 20'h00100 then read back gives cpu_i=8'h5A; dma_gnt stays 0.
- DMA single write, 20'hB8000 <- 8'h41: dma_gnt=1 one cycle after dma_req; mem_w=1 for exactly one cycle with mem_a=20'hB8000; dma_ack the next cycle; cpu_ce=0 only during S_DMA cycles.
- BURST=8, dma_req held for 20 read addresses: access pattern 8 DMA, 1 CPU (cpu_ce=1), 8 DMA, 1 CPU, 4 DMA; 20 dma_ack pulses, each dma_i matching preloaded memory.
- dma_req deasserted while granted: no mem_w in the deassert cycle; return to S_CPU the next cycle; count restarts at 0 on the next request.
- Reset asserted during the third beat of a DMA burst: next cycle S_CPU, dma_gnt=0, dma_ack=0, no write reaches memory in the reset cycle.
- MEM_BUS_ROM_WP_EN with a CPU write to 20'hFF900 and a DMA write to 20'hFFFF0: mem_w=0 for both; wp_hit pulses twice; a write to 20'hFF7FF goes through.
